// File: rtl/swc_lost_pck_free_arbiter.sv
// Round-robin arbiter sharing the allocator's force-free port among the
// per-port lost-packet requesters (input blocks first, then output blocks).
// Each requester holds at most one outstanding free. A strobe that arrives
// while that requester is still outstanding is dropped and flagged.
module swc_lost_pck_free_arbiter #(
  parameter int NUM_PORTS      = 11,
  parameter int PAGE_ADDR_BITS = 10
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_PORTS-1:0]                ib_force_free_i,
  input  logic [NUM_PORTS*PAGE_ADDR_BITS-1:0] ib_pgaddr_free_i,
  output logic [NUM_PORTS-1:0]                ib_force_free_done_o,
  input  logic [NUM_PORTS-1:0]                ob_force_free_i,
  input  logic [NUM_PORTS*PAGE_ADDR_BITS-1:0] ob_pgaddr_free_i,
  output logic [NUM_PORTS-1:0]                ob_force_free_done_o,
  output logic                                mmu_force_free_o,
  output logic [PAGE_ADDR_BITS-1:0]           mmu_force_free_addr_o,
  input  logic                                mmu_force_free_done_i,
  output logic                                drop_o
);

  localparam int R  = 2 * NUM_PORTS;
  localparam int PW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t                    state_reg, state_next;
  logic [R-1:0]              pending_reg, pending_next;
  logic [PW-1:0]             rr_ptr_reg, rr_ptr_next;
  logic [PW-1:0]             sel_reg, sel_next;
  logic                      req_reg, req_next;
  logic [PAGE_ADDR_BITS-1:0] addr_reg, addr_next;
  logic [R-1:0]              done_reg, done_next;
  logic                      drop_reg, drop_next;

  logic [R-1:0]              strobe;
  logic [R-1:0]              accept;
  logic [R-1:0]              clear_mask;
  logic [PAGE_ADDR_BITS-1:0] strobe_addr [R];
  logic [PAGE_ADDR_BITS-1:0] addr_q      [R];

  logic                      grant_found;
  logic [PW-1:0]             grant_idx;
  logic [PW:0]               scan_idx;

  // Flatten the two port groups into one requester space: ib p -> p, ob p -> NUM_PORTS+p
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_map
    assign strobe[gi]                  = ib_force_free_i[gi];
    assign strobe[NUM_PORTS+gi]        = ob_force_free_i[gi];
    assign strobe_addr[gi]             = ib_pgaddr_free_i[gi*PAGE_ADDR_BITS +: PAGE_ADDR_BITS];
    assign strobe_addr[NUM_PORTS+gi]   = ob_pgaddr_free_i[gi*PAGE_ADDR_BITS +: PAGE_ADDR_BITS];
  end

  // A strobe only lands when its requester has nothing outstanding
  assign accept = strobe & ~pending_reg;

  // Per-requester address latch, written only on an accepted strobe
  for (genvar gi = 0; gi < R; gi++) begin : g_addr
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        addr_q[gi] <= '0;
      end else if (accept[gi]) begin
        addr_q[gi] <= strobe_addr[gi];
      end
    end
  end

  // Circular scan for the first pending requester starting at rr_ptr
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int i = 0; i < R; i++) begin
      scan_idx = {1'b0, rr_ptr_reg} + (PW+1)'(i);
      if (scan_idx >= (PW+1)'(R)) begin
        scan_idx = scan_idx - (PW+1)'(R);
      end
      if (!grant_found && pending_reg[scan_idx[PW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[PW-1:0];
      end
    end
  end

  // Next-state, grant, completion and pending bookkeeping
  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    rr_ptr_next = rr_ptr_reg;
    req_next    = req_reg;
    addr_next   = addr_reg;
    done_next   = '0;
    clear_mask  = '0;

    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          sel_next   = grant_idx;
          addr_next  = addr_q[grant_idx];
          req_next   = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (mmu_force_free_done_i) begin
          req_next             = 1'b0;
          done_next[sel_reg]   = 1'b1;
          clear_mask[sel_reg]  = 1'b1;
          rr_ptr_next          = (sel_reg == PW'(R-1)) ? '0 : sel_reg + 1'b1;
          state_next           = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Clear and accept never hit the same bit: a pending requester cannot be accepted
    pending_next = (pending_reg & ~clear_mask) | accept;
    drop_next    = |(strobe & pending_reg);
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      rr_ptr_reg  <= '0;
      sel_reg     <= '0;
      req_reg     <= 1'b0;
      addr_reg    <= '0;
      done_reg    <= '0;
      drop_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      rr_ptr_reg  <= rr_ptr_next;
      sel_reg     <= sel_next;
      req_reg     <= req_next;
      addr_reg    <= addr_next;
      done_reg    <= done_next;
      drop_reg    <= drop_next;
    end
  end

  assign mmu_force_free_o      = req_reg;
  assign mmu_force_free_addr_o = addr_reg;
  assign ib_force_free_done_o  = done_reg[NUM_PORTS-1:0];
  assign ob_force_free_done_o  = done_reg[R-1:NUM_PORTS];
  assign drop_o                = drop_reg;

endmodule

// File: tb/tb_swc_lost_pck_free_arbiter.sv
// Scoreboard bench for the lost-packet free arbiter. A transaction-level
// reference model predicts grants, done pulses and drops with their cycle
// numbers; a monitor on the falling edge pops and compares them.
module tb_swc_lost_pck_free_arbiter;

  localparam int NP = 11;
  localparam int W  = 10;
  localparam int R  = 2 * NP;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   ib_ff, ob_ff;
  logic [NP*W-1:0] ib_addr, ob_addr;
  logic [NP-1:0]   ib_done, ob_done;
  logic            req;
  logic [W-1:0]    maddr;
  logic            ack;
  logic            drop;

  swc_lost_pck_free_arbiter #(.NUM_PORTS(NP), .PAGE_ADDR_BITS(W)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .ib_force_free_i       (ib_ff),
    .ib_pgaddr_free_i      (ib_addr),
    .ib_force_free_done_o  (ib_done),
    .ob_force_free_i       (ob_ff),
    .ob_pgaddr_free_i      (ob_addr),
    .ob_force_free_done_o  (ob_done),
    .mmu_force_free_o      (req),
    .mmu_force_free_addr_o (maddr),
    .mmu_force_free_done_i (ack),
    .drop_o                (drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tag;
    int r;
    int addr;
  } ev_t;

  ev_t grant_q[$];
  ev_t done_q[$];
  int  drop_q[$];

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;
  int rst_chk  = -1;
  int ack_min  = 0;
  int ack_max  = 0;
  bit idle_noise = 1'b0;

  // Reference model state: outstanding set, latched pages, service pointer
  bit [R-1:0] m_pend = '0;
  int         m_addr [R];
  bit         m_busy = 1'b0;
  int         m_sel  = 0;
  int         m_ptr  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  function automatic bit strobe_of(input int r);
    if (r < NP) return ib_ff[r];
    return ob_ff[r-NP];
  endfunction

  function automatic int addr_of(input int r);
    if (r < NP) return int'(ib_addr[r*W +: W]);
    return int'(ob_addr[(r-NP)*W +: W]);
  endfunction

  // Apply one clock edge's worth of the arbitration rules to the model
  task automatic model_edge();
    bit [R-1:0] old_pend;
    bit         any_drop;
    int         rr;
    if (rst) begin
      m_pend  = '0;
      m_busy  = 1'b0;
      m_ptr   = 0;
      rst_chk = cyc;
      return;
    end
    old_pend = m_pend;
    if (m_busy) begin
      if (ack) begin
        done_q.push_back('{cyc, m_sel, 0});
        m_pend[m_sel] = 1'b0;
        m_ptr  = (m_sel + 1) % R;
        m_busy = 1'b0;
      end
    end else begin
      for (int k = 0; k < R; k++) begin
        rr = (m_ptr + k) % R;
        if (old_pend[rr]) begin
          grant_q.push_back('{cyc, rr, m_addr[rr]});
          m_busy = 1'b1;
          m_sel  = rr;
          break;
        end
      end
    end
    any_drop = 1'b0;
    for (int r = 0; r < R; r++) begin
      if (strobe_of(r)) begin
        if (old_pend[r]) any_drop = 1'b1;
        else begin
          m_pend[r] = 1'b1;
          m_addr[r] = addr_of(r);
        end
      end
    end
    if (any_drop) drop_q.push_back(cyc);
  endtask

  task automatic post(input int r, input int a);
    if (r < NP) begin
      ib_ff[r] = 1'b1;
      ib_addr[r*W +: W] = W'(a);
    end else begin
      ob_ff[r-NP] = 1'b1;
      ob_addr[(r-NP)*W +: W] = W'(a);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    ib_ff = '0;
    ob_ff = '0;
    rst   = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain();
    int guard = 0;
    while ((m_busy || m_pend != '0) && guard < 1000) begin
      step();
      guard++;
    end
    check("drain_outstanding", longint'(m_busy || m_pend != '0), 0);
    run(4);
  endtask

  // Allocator model: acknowledges after a programmable delay, optional idle noise
  initial begin
    int wait_cnt;
    int cur_delay;
    ack = 1'b0;
    wait_cnt  = 0;
    cur_delay = 0;
    forever begin
      @(posedge clk);
      #1;
      if (req) begin
        if (wait_cnt >= cur_delay) ack = 1'b1;
        else begin
          ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        wait_cnt  = 0;
        cur_delay = int'($urandom_range(ack_max, ack_min));
        ack = idle_noise && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Monitor: compare every DUT output event against the model's queues
  logic prev_req = 1'b0;
  int   cur_exp_addr = 0;
  always @(negedge clk) begin
    ev_t e;
    int  t;
    logic [R-1:0] dv;
    if (cyc > 0) begin
      while (grant_q.size() > 0 && grant_q[0].tag < cyc) begin
        e = grant_q.pop_front();
        check("grant_missing_req", 0, e.r);
      end
      while (done_q.size() > 0 && done_q[0].tag < cyc) begin
        e = done_q.pop_front();
        check("done_missing_req", 0, e.r);
      end
      while (drop_q.size() > 0 && drop_q[0] < cyc) begin
        t = drop_q.pop_front();
        check("drop_missing_cycle", 0, t);
      end

      if (rst_chk == cyc)
        check("reset_outputs", longint'({req, maddr, ib_done, ob_done, drop}), 0);

      if (req && !prev_req) begin
        if (grant_q.size() == 0) check("grant_unexpected", 1, 0);
        else begin
          e = grant_q.pop_front();
          check("grant_cycle", cyc, e.tag);
          check("grant_addr", maddr, e.addr);
          cur_exp_addr = e.addr;
        end
      end else if (req) begin
        check("req_hold_addr", maddr, cur_exp_addr);
      end

      dv = {ob_done, ib_done};
      if (dv != '0) begin
        if (done_q.size() == 0) check("done_unexpected", longint'(dv), 0);
        else begin
          e = done_q.pop_front();
          check("done_cycle", cyc, e.tag);
          check("done_vec", longint'(dv), longint'(64'(1) << e.r));
        end
      end

      if (drop) begin
        if (drop_q.size() == 0) check("drop_unexpected", 1, 0);
        else begin
          t = drop_q.pop_front();
          check("drop_cycle", cyc, t);
        end
      end
      prev_req = req;
    end
  end

  initial begin
    int g;
    ib_ff = '0; ob_ff = '0; ib_addr = '0; ob_addr = '0;
    rst = 1'b1;
    repeat (3) begin
      rst = 1'b1;
      step();
    end
    run(2);

    // Single request, immediate ack
    post(3, 'h155);
    step();
    run(6);

    // Full load: every requester at once
    for (int r = 0; r < R; r++) post(r, 'h100 + r);
    step();
    run(50);
    drain();

    // Fairness: ib0 re-strobes in each of its done cycles, ob5 must still be served
    post(0, 'h011);
    post(NP + 5, 'h0B5);
    step();
    repeat (30) begin
      if (ib_done[0]) post(0, int'($urandom_range(0, 1023)));
      step();
    end
    drain();

    // Duplicate strobe while pending
    post(7, 'h0AA);
    step();
    post(7, 'h3FF);
    step();
    drain();

    // Allocator stall of five cycles
    ack_min = 5; ack_max = 5;
    post(NP + 2, 'h2C2);
    step();
    drain();

    // Reset while a request is outstanding
    ack_min = 10; ack_max = 10;
    post(4, 'h044); post(5, 'h055); post(NP + 6, 'h166); post(NP + 8, 'h188);
    step();
    g = 0;
    while (!req && g < 10) begin
      step();
      g++;
    end
    check("req_before_reset", req, 1);
    rst = 1'b1;
    step();
    run(4);
    ack_min = 0; ack_max = 0;
    post(1, 'h101);
    post(NP, 'h200);
    step();
    drain();

    // Random traffic with random ack delays, idle acks and occasional resets
    ack_min = 0; ack_max = 3; idle_noise = 1'b1;
    repeat (1500) begin
      for (int r = 0; r < R; r++)
        if ($urandom_range(0, 99) < 4) post(r, int'($urandom_range(0, 1023)));
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
      step();
    end
    idle_noise = 1'b0;
    drain();

    check("grant_q_empty", grant_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    check("drop_q_empty", drop_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
